// File: rtl/monkey_key_decoder.sv
// rtl/monkey_key_decoder.sv - PS/2 set-2 scan codes to frame-latched monkey move/jump commands (optional macro KEY_ARROWS_EN)
module monkey_key_decoder #(
    parameter logic [7:0] LEFT_CODE   = 8'h6B,
    parameter logic [7:0] RIGHT_CODE  = 8'h74,
    parameter logic [7:0] JUMP_CODE   = 8'h29,
    parameter logic [3:0] LEFT_DIGIT  = 4'd4,
    parameter logic [3:0] RIGHT_DIGIT = 4'd6
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       byteValid,
    input  logic [7:0] byteData,
    output logic       digitIsPressed,
    output logic [3:0] digit,
    output logic       jumpIsPressed
);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

    state_t     state_q, state_d;
    logic       left_held_q, left_held_d;
    logic       right_held_q, right_held_d;
    logic       jump_held_q, jump_held_d;
    logic       last_dir_q, last_dir_d;          // 1: right was pressed last
    logic       jump_pending_q, jump_pending_d;
    logic       dir_pressed_q, dir_pressed_d;
    logic [3:0] digit_q, digit_d;
    logic       jump_out_q, jump_out_d;

    logic is_ext, is_brk, is_err, is_prefix_e0, is_prefix_f0;
    logic hit_left, hit_right, hit_jump;
    logic ext_left, ext_right, ext_jump;
    logic dir_valid, dir_right;

`ifdef KEY_ARROWS_EN
    // Arrow keys (extended codes) alias onto the keypad keys
    assign ext_left  = (byteData == 8'h6B);
    assign ext_right = (byteData == 8'h74);
    assign ext_jump  = (byteData == 8'h75);
`else
    assign ext_left  = 1'b0;
    assign ext_right = 1'b0;
    assign ext_jump  = 1'b0;
`endif

    assign is_ext       = (state_q == EXT) || (state_q == EXTBRK);
    assign is_brk       = (state_q == BRK) || (state_q == EXTBRK);
    assign is_err       = (byteData == 8'hAA) || (byteData == 8'hFC) ||
                          (byteData == 8'h00) || (byteData == 8'hFF);
    assign is_prefix_e0 = (byteData == 8'hE0);
    assign is_prefix_f0 = (byteData == 8'hF0);

    assign hit_left  = is_ext ? ext_left  : (byteData == LEFT_CODE);
    assign hit_right = is_ext ? ext_right : (byteData == RIGHT_CODE);
    assign hit_jump  = is_ext ? ext_jump  : (byteData == JUMP_CODE);

    // Resolved direction from the pre-byte held state: last-pressed wins on conflict
    assign dir_valid = left_held_q || right_held_q;
    assign dir_right = (left_held_q && right_held_q) ? last_dir_q : right_held_q;

    // Next-state: frame latch first, then byte parsing so a coincident jump make wins over the clear
    always_comb begin
        state_d        = state_q;
        left_held_d    = left_held_q;
        right_held_d   = right_held_q;
        jump_held_d    = jump_held_q;
        last_dir_d     = last_dir_q;
        jump_pending_d = jump_pending_q;
        dir_pressed_d  = dir_pressed_q;
        digit_d        = digit_q;
        jump_out_d     = jump_out_q;

        if (startOfFrame) begin
            dir_pressed_d  = dir_valid;
            digit_d        = !dir_valid ? 4'd0 : (dir_right ? RIGHT_DIGIT : LEFT_DIGIT);
            jump_out_d     = jump_pending_q;
            jump_pending_d = 1'b0;
        end

        if (byteValid) begin
            if (is_err) begin
                state_d        = IDLE;
                left_held_d    = 1'b0;
                right_held_d   = 1'b0;
                jump_held_d    = 1'b0;
                last_dir_d     = 1'b0;
                jump_pending_d = 1'b0;
            end else if (is_prefix_e0) begin
                state_d = is_brk ? EXTBRK : EXT;
            end else if (is_prefix_f0) begin
                state_d = is_ext ? EXTBRK : BRK;
            end else begin
                state_d = IDLE;
                if (hit_left) begin
                    left_held_d = !is_brk;
                    if (!is_brk) last_dir_d = 1'b0;
                end
                if (hit_right) begin
                    right_held_d = !is_brk;
                    if (!is_brk) last_dir_d = 1'b1;
                end
                if (hit_jump) begin
                    jump_held_d = !is_brk;
                    if (!is_brk && !jump_held_q) jump_pending_d = 1'b1;
                end
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q        <= IDLE;
            left_held_q    <= 1'b0;
            right_held_q   <= 1'b0;
            jump_held_q    <= 1'b0;
            last_dir_q     <= 1'b0;
            jump_pending_q <= 1'b0;
            dir_pressed_q  <= 1'b0;
            digit_q        <= 4'd0;
            jump_out_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            left_held_q    <= left_held_d;
            right_held_q   <= right_held_d;
            jump_held_q    <= jump_held_d;
            last_dir_q     <= last_dir_d;
            jump_pending_q <= jump_pending_d;
            dir_pressed_q  <= dir_pressed_d;
            digit_q        <= digit_d;
            jump_out_q     <= jump_out_d;
        end
    end

    assign digitIsPressed = dir_pressed_q;
    assign digit          = digit_q;
    assign jumpIsPressed  = jump_out_q;

endmodule
